// File: rtl/button_conditioner.sv
// Raw push-button front end: synchronise, debounce, detect presses, optionally
// auto-repeat a held button, and hand decided moves over a one-entry valid/ready buffer.
module button_conditioner #(
    parameter int N_BTN         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 650000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 32500000,
    parameter int REPEAT_PERIOD = 9750000,
    localparam int DIR_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk_65,
    input  logic             rst,
    input  logic [N_BTN-1:0] button_press,
    input  logic             move_ready,
    output logic             move_valid,
    output logic [DIR_W-1:0] move_dir,
    output logic [N_BTN-1:0] btn_level,
    output logic             overrun
);
    localparam int CNT_W   = $clog2(DB_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W    = $clog2(REP_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [RC_W-1:0]  DLY_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  PER_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rstate_t;

    logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
    logic [N_BTN-1:0][CNT_W-1:0]       db_cnt_q, db_cnt_d;
    logic [N_BTN-1:0]                  level_q, level_d, level_prev_q;
    logic [N_BTN-1:0]                  sync_s, press_vec;
    logic                              press_any;
    logic [DIR_W-1:0]                  press_idx;

    rstate_t          rstate_q, rstate_d;
    logic [DIR_W-1:0] rk_q, rk_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic             rep_evt;

    logic             valid_q, valid_d, ovr_q, ovr_d, evt, xfer;
    logic [DIR_W-1:0] dir_q, dir_d, evt_dir;

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign press_vec = level_q & ~level_prev_q;

    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync_s[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                level_d[i]  = ~level_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Scan high to low so the lowest simultaneous press index ends up selected.
    always_comb begin
        press_any = 1'b0;
        press_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_vec[i]) begin
                press_any = 1'b1;
                press_idx = DIR_W'(i);
            end
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rk_d     = rk_q;
        rcnt_d   = rcnt_q;
        rep_evt  = 1'b0;
        if (REPEAT_EN == 0) begin
            rstate_d = R_IDLE;
            rcnt_d   = '0;
        end else if (press_any) begin
            rk_d     = press_idx;
            rcnt_d   = '0;
            rstate_d = R_DELAY;
        end else begin
            case (rstate_q)
                R_DELAY, R_REPEAT: begin
                    if (!level_q[rk_q]) begin
                        rstate_d = R_IDLE;
                        rcnt_d   = '0;
                    end else if (rcnt_q == ((rstate_q == R_DELAY) ? DLY_LAST : PER_LAST)) begin
                        rep_evt  = 1'b1;
                        rcnt_d   = '0;
                        rstate_d = R_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + RC_W'(1);
                    end
                end
                default: rcnt_d = '0;
            endcase
        end
    end

    // A fresh press always outranks a repeat falling in the same cycle.
    assign evt     = press_any | rep_evt;
    assign evt_dir = press_any ? press_idx : rk_q;
    assign xfer    = valid_q & move_ready;

    always_comb begin
        valid_d = valid_q;
        dir_d   = dir_q;
        ovr_d   = 1'b0;
        if (evt) begin
            if (!valid_q || xfer) begin
                valid_d = 1'b1;
                dir_d   = evt_dir;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_65 or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            db_cnt_q     <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            rstate_q     <= R_IDLE;
            rk_q         <= '0;
            rcnt_q       <= '0;
            valid_q      <= 1'b0;
            dir_q        <= '0;
            ovr_q        <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], button_press};
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            rstate_q     <= rstate_d;
            rk_q         <= rk_d;
            rcnt_q       <= rcnt_d;
            valid_q      <= valid_d;
            dir_q        <= dir_d;
            ovr_q        <= ovr_d;
        end
    end

    assign move_valid = valid_q;
    assign move_dir   = dir_q;
    assign btn_level  = level_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one instance without and one with auto-repeat.
module tb_button_conditioner;
    logic       clk_65 = 1'b0;
    logic       rst;
    logic [3:0] btn, r_btn;
    logic       ready, r_ready;
    logic       valid, r_valid, ovr, r_ovr;
    logic [1:0] dir, r_dir;
    logic [3:0] lvl, r_lvl;
    int checks = 0;
    int failures = 0;

    always #5 clk_65 = ~clk_65;

    button_conditioner #(.N_BTN(4), .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_EN(0),
                         .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) u_dut (
        .clk_65(clk_65), .rst(rst), .button_press(btn), .move_ready(ready),
        .move_valid(valid), .move_dir(dir), .btn_level(lvl), .overrun(ovr));

    button_conditioner #(.N_BTN(4), .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_EN(1),
                         .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) u_rep (
        .clk_65(clk_65), .rst(rst), .button_press(r_btn), .move_ready(r_ready),
        .move_valid(r_valid), .move_dir(r_dir), .btn_level(r_lvl), .overrun(r_ovr));

    task automatic tick();
        @(posedge clk_65);
        #1;
    endtask

    task automatic consume_and_release();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        btn = 4'b0000;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        btn = '0; r_btn = '0; ready = 1'b0; r_ready = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
        checks++; if (dir !== 2'd0) begin failures++; $display("FAIL rst_dir got=%0d exp=0", dir); end
        checks++; if (lvl !== 4'b0000) begin failures++; $display("FAIL rst_lvl got=%b exp=0000", lvl); end
        checks++; if (ovr !== 1'b0 || r_ovr !== 1'b0 || r_valid !== 1'b0) begin
            failures++; $display("FAIL rst_misc got ovr=%b r_ovr=%b r_valid=%b exp=0", ovr, r_ovr, r_valid);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_press();
        int bad;
        btn = 4'b1000;
        repeat (5) tick();
        checks++; if (lvl !== 4'b0000) begin failures++; $display("FAIL t1_lvl_early got=%b exp=0000", lvl); end
        tick();
        checks++; if (lvl !== 4'b1000) begin failures++; $display("FAIL t1_lvl_c5 got=%b exp=1000", lvl); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL t1_valid_c5 got=%b exp=0", valid); end
        tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL t1_valid_c6 got=%b exp=1", valid); end
        checks++; if (dir !== 2'd3) begin failures++; $display("FAIL t1_dir got=%0d exp=3", dir); end
        bad = 0;
        repeat (50) begin
            tick();
            if (valid !== 1'b1 || dir !== 2'd3 || ovr !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL t1_hold bad_cycles=%0d exp=0", bad); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL t1_consume got=%b exp=0", valid); end
        btn = 4'b0000;
        repeat (10) tick();
        checks++; if (valid !== 1'b0 || lvl !== 4'b0000) begin
            failures++; $display("FAIL t1_release got valid=%b lvl=%b exp 0/0000", valid, lvl);
        end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            btn[1] = (((c / 2) % 2) == 0);
            tick();
            if (lvl !== 4'b0000 || valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL t2_bounce bad_cycles=%0d exp=0", bad); end
        btn[1] = 1'b1;
        repeat (5) tick();
        checks++; if (lvl !== 4'b0000) begin failures++; $display("FAIL t2_lvl_early got=%b exp=0000", lvl); end
        tick();
        checks++; if (lvl !== 4'b0010 || valid !== 1'b0) begin
            failures++; $display("FAIL t2_c5 got lvl=%b valid=%b exp 0010/0", lvl, valid);
        end
        tick();
        checks++; if (valid !== 1'b1 || dir !== 2'd1) begin
            failures++; $display("FAIL t2_move got valid=%b dir=%0d exp 1/1", valid, dir);
        end
        consume_and_release();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL t2_single got valid=%b exp=0", valid); end
    endtask

    task automatic test_simultaneous();
        btn = 4'b0101;
        repeat (7) tick();
        checks++; if (valid !== 1'b1 || dir !== 2'd0) begin
            failures++; $display("FAIL t3_move got valid=%b dir=%0d exp 1/0", valid, dir);
        end
        checks++; if (lvl !== 4'b0101) begin failures++; $display("FAIL t3_lvl got=%b exp=0101", lvl); end
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL t3_ovr got=%b exp=0", ovr); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL t3_loser got valid=%b exp=0", valid); end
        btn = 4'b0000;
        repeat (10) tick();
    endtask

    task automatic test_overrun();
        btn = 4'b1000;
        repeat (7) tick();
        checks++; if (valid !== 1'b1 || dir !== 2'd3) begin
            failures++; $display("FAIL t4_first got valid=%b dir=%0d exp 1/3", valid, dir);
        end
        btn = 4'b1010;
        repeat (6) tick();
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL t4_ovr_early got=%b exp=0", ovr); end
        tick();
        checks++; if (ovr !== 1'b1) begin failures++; $display("FAIL t4_ovr_pulse got=%b exp=1", ovr); end
        tick();
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL t4_ovr_end got=%b exp=0", ovr); end
        checks++; if (valid !== 1'b1 || dir !== 2'd3) begin
            failures++; $display("FAIL t4_kept got valid=%b dir=%0d exp 1/3", valid, dir);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL t4_drain got=%b exp=0", valid); end
        btn = 4'b0000;
        repeat (10) tick();
    endtask

    task automatic test_repeat();
        int exp_t[6] = '{7, 27, 35, 43, 51, 59};
        int got_t[$];
        int bad_dir, n_ovr;
        bad_dir = 0; n_ovr = 0;
        r_ready = 1'b1;
        r_btn = 4'b0100;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (r_valid === 1'b1) begin
                got_t.push_back(t);
                if (r_dir !== 2'd2) bad_dir++;
            end
            if (r_ovr !== 1'b0) n_ovr++;
            if (t == 60) r_btn = 4'b0000;
        end
        checks++; if (got_t.size() != 6) begin
            failures++; $display("FAIL t5_count got=%0d exp=6", got_t.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < got_t.size()) begin
                checks++; if (got_t[i] != exp_t[i]) begin
                    failures++; $display("FAIL t5_time[%0d] got=%0d exp=%0d", i, got_t[i], exp_t[i]);
                end
            end
        end
        checks++; if (bad_dir != 0 || n_ovr != 0) begin
            failures++; $display("FAIL t5_dir_ovr got bad_dir=%0d ovr_cycles=%0d exp 0/0", bad_dir, n_ovr);
        end
        r_ready = 1'b0;
    endtask

    task automatic test_reset_pending();
        btn = 4'b0001;
        repeat (7) tick();
        checks++; if (valid !== 1'b1 || dir !== 2'd0) begin
            failures++; $display("FAIL t6_pending got valid=%b dir=%0d exp 1/0", valid, dir);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (valid !== 1'b0 || lvl !== 4'b0000 || ovr !== 1'b0 || dir !== 2'd0) begin
            failures++; $display("FAIL t6_async got valid=%b lvl=%b ovr=%b dir=%0d exp all 0", valid, lvl, ovr, dir);
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        checks++; if (valid !== 1'b0 || lvl !== 4'b0001) begin
            failures++; $display("FAIL t6_c5 got valid=%b lvl=%b exp 0/0001", valid, lvl);
        end
        tick();
        checks++; if (valid !== 1'b1 || dir !== 2'd0) begin
            failures++; $display("FAIL t6_fresh got valid=%b dir=%0d exp 1/0", valid, dir);
        end
        consume_and_release();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_overrun();
        test_repeat();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised front end between the raw push-buttons and the 2048 game FSM.
- Per-button path: N-stage synchroniser, then debounce, then press-edge detection.
- Optional hold-to-repeat (auto-repeat) mode.
- Decided moves go through a one-entry valid/ready buffer, so the game FSM takes exactly one move per accepted handshake and never sees a glitch or a double move.

Parameters:
- N_BTN, 4: number of button inputs; bit index = direction code.
- SYNC_STAGES, 2: synchroniser flops per input (min 2).
- DB_CYCLES, 650000: stable cycles required before a level is accepted (10 ms at 65 MHz; min 1).
- REPEAT_EN, 0: 1 enables auto-repeat while a button is held.
- REPEAT_DELAY, 32500000: hold cycles before the first repeat (500 ms).
- REPEAT_PERIOD, 9750000: cycles between subsequent repeats (150 ms).
- DIR_W (derived localparam), clog2(N_BTN), min 1: width of move_dir.

Ports:
- clk_65  input  1  system clock, 65 MHz pixel clock domain.
- rst  input  1  asynchronous, active-high reset.
- button_press  input  N_BTN  raw asynchronous button levels, 1 = pressed.
- move_ready  input  1  game FSM can accept a move this cycle.
- move_valid  output  1  a buffered move is pending.
- move_dir  output  DIR_W  index of the pending move's button; held stable while move_valid=1.
- btn_level  output  N_BTN  debounced button levels.
- overrun  output  1  one-cycle pulse when an event is dropped because the buffer is full.

Behaviour:
- Reset (async assert, sync release): synchroniser flops, debounce counters, btn_level, repeat FSM, move_valid, move_dir and overrun all go to 0.
  - A pending move is discarded.
  - A button held through reset release produces a fresh press once debounce completes.
- Synchroniser: each bit passes through SYNC_STAGES flops; s[i] is the last stage.
- Debounce, per bit, counter of width clog2(DB_CYCLES+1):
  - If s[i]==btn_level[i], the counter clears.
  - Otherwise the counter increments; when it reaches DB_CYCLES-1, btn_level[i] toggles and the counter clears.
  - Any bounce back to the old level before the terminal count restarts the count.
- Press event: btn_level[i] goes 0 to 1. Release produces no event.
- Simultaneous press events in the same cycle: the lowest index wins; the others are discarded silently.
- Latency: raw input changes and is held steady. The first clk_65 edge that samples it is cycle 0.
  - btn_level changes at cycle SYNC_STAGES+DB_CYCLES-1.
  - move_valid rises at cycle SYNC_STAGES+DB_CYCLES.
- Repeat FSM (REPEAT_EN=1). States IDLE, DELAY, REPEAT; tracks a single button k and one shared counter.
  - Any press event (from any state) loads k, clears the counter and enters DELAY.
  - DELAY: counter reaches REPEAT_DELAY-1 → emit event k, clear the counter, enter REPEAT.
  - REPEAT: counter reaches REPEAT_PERIOD-1 → emit event k, clear the counter.
  - btn_level[k]=0 in DELAY or REPEAT → IDLE, no event.
  - If a repeat event and a press event fall in the same cycle, the press wins and the FSM retracks.
  - With REPEAT_EN=0 the FSM is held in IDLE.
- Output buffer, one entry:
  - Transfer occurs on a cycle where move_valid && move_ready.
  - Event with buffer empty: load; move_valid=1 and move_dir=index from the next cycle.
  - Transfer with no new event: move_valid=0 next cycle.
  - Transfer and new event in the same cycle: the new event loads; move_valid stays 1 and move_dir updates.
  - Event with buffer full and no transfer: event dropped, buffered entry unchanged, overrun=1 for the next cycle only.
  - move_ready while move_valid=0 has no effect.

Test Plan:
(All use SYNC_STAGES=2, DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.)
1. Reset, then raw bit 3 goes 0→1 and holds, move_ready=0 → btn_level[3]=1 at cycle 5; move_valid=1 with move_dir=3 at cycle 6; the state stays pending for 50 cycles with no second event.
2. Bounce: bit 1 toggles every 2 cycles for 20 cycles, then settles at 1 → exactly one move, move_dir=1, 6 cycles after settling; btn_level[1] makes no intermediate toggles.
3. Bits 2 and 0 rise in the same cycle → a single move with move_dir=0; btn_level=4'b0101.
4. Buffer full (dir 3 pending, move_ready=0), then a press on bit 1 → overrun is a single one-cycle pulse; move_dir stays 3. Then set move_ready=1 for one cycle with no new event → move_valid drops the next cycle.
5. REPEAT_EN=1, bit 2 held for 60 cycles after debounce, move_ready=1 → moves at t0, t0+20, t0+28, t0+36, t0+44, t0+52. Release bit 2 → no further moves after the release is debounced.
6. rst asserted while a move is pending and bit 0 is still held → outputs go to 0 immediately, asynchronously. After release: a fresh move_dir=0 event at cycle 6.
